insn_load_sequencer: RTL
========================

Name: insn_load_sequencer

Overview:
- Controls the per-core instruction memory through two phases: program load, then fetch sequencing.
- Load phase: runs the host-to-memory load handshake, drives the memory write strobe and beat counter, and fills the memory in LOAD_BEATS bus beats.
- Run phase: enables the core and generates the fetch pointer, handling stall, branch and stop, until the program ends.
- Returns to idle after the program ends. Host instruction data goes directly to the memory; this block only sequences it.

Parameters:
- LOAD_BEATS, 8, number of bus beats that fill the whole memory.
- CNT_W, 3, width of the beat counter; must satisfy 2**CNT_W >= LOAD_BEATS.
- PTR_W, 8, instruction pointer width; the memory depth is 2**PTR_W.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous reset, active-low; reset==0 at a rising edge resets the block.
- start  in  1  host request to load a new program; sampled in IDLE only.
- data_valid  in  1  host bus beat valid.
- data_ready  out  1  sequencer accepts a beat.
- init_insn_mem  out  1  write strobe to the instruction memory.
- insn_load_counter  out  CNT_W  index of the beat being written.
- stall  in  1  core pipeline stall; holds the pointer.
- branch_en  in  1  take branch this cycle.
- branch_target  in  PTR_W  branch destination.
- stop  in  1  core decoded its stop instruction.
- insn_ptr  out  PTR_W  fetch address to the instruction memory.
- core_run  out  1  core enable.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the program ends.
- err  out  1  sticky flag: pointer overflowed the end of memory.

Behaviour:
- Reset values: state=IDLE, insn_load_counter=0, insn_ptr=0, err=0. All other outputs are 0. Reset does not clear memory contents.
- Reset mid-LOAD or mid-RUN aborts to IDLE in that same edge. A partially loaded program stays in memory and is not valid.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - data_ready=0, core_run=0, insn_ptr=0.
  - start=1 -> LOAD; counter<=0; err<=0.
- LOAD:
  - data_ready=1.
  - init_insn_mem = data_valid, combinational (zero latency). The memory samples host data and insn_load_counter on the same edge.
  - On an accepted beat (valid & ready): counter<=counter+1.
  - No valid: counter holds. start is ignored.
  - Accepted beat with counter==LOAD_BEATS-1 -> RUN; counter<=0; insn_ptr<=0.
- RUN:
  - core_run=1, data_ready=0, init_insn_mem=0.
  - Per-edge priority: stop > stall > branch_en > sequential increment.
  - stop=1: insn_ptr holds; -> DONE.
  - stall=1: insn_ptr holds. A concurrent branch_en is dropped; the core must re-assert it after the stall.
  - branch_en=1: insn_ptr<=branch_target. Any target is legal, since the full 2**PTR_W range is covered.
  - Otherwise insn_ptr<=insn_ptr+1.
  - Increment at insn_ptr==2**PTR_W-1: no wrap; err<=1; insn_ptr holds; -> DONE.
- DONE:
  - core_run=0; done=1 for exactly one cycle; -> IDLE (insn_ptr<=0).
  - err stays set until the next start is accepted in IDLE.
- Simultaneous stop and overflow: stop wins and err stays 0.
- start during LOAD, RUN or DONE is ignored and not queued.
- Single cycle from the last accepted beat to RUN. The first core fetch is address 0 on the first RUN cycle.

Test Plan:
- Load: after reset release, pulse start, then drive 8 beats with data_valid high continuously -> init_insn_mem high for exactly 8 cycles with counter 0..7; RUN entered on the next edge; insn_ptr=0; core_run=1.
- Gapped load: insert a valid=0 bubble after beats 2 and 5 -> counter holds during the bubbles; exactly 8 strobes; RUN entered only after counter 7 is accepted.
- Sequencing: in RUN, 3 free cycles, then stall for 2, then branch_en with target 0x40, then stop -> insn_ptr 0,1,2,3,3,3,0x40; then DONE; one-cycle done pulse; IDLE with insn_ptr=0.
- Stall/branch conflict and overflow: stall=1 with branch_en=1 -> insn_ptr unchanged. Branch to 0xFF, then one free cycle -> err=1, done pulse, IDLE; err clears on the next start.
- Reset mid-LOAD: assert reset=0 at beat 4 -> next edge shows IDLE, counter=0, data_ready=0. A new start reloads from counter 0.
- Ignored start: start pulses during LOAD and RUN -> no counter reset and no state change; busy stays 1 throughout.

Source files
------------

// File: rtl/insn_load_sequencer.sv
// rtl/insn_load_sequencer.sv - instruction memory load and fetch sequencer
module insn_load_sequencer #(
  parameter int LOAD_BEATS = 8,
  parameter int CNT_W      = 3,
  parameter int PTR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             init_insn_mem,
  output logic [CNT_W-1:0] insn_load_counter,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [PTR_W-1:0] branch_target,
  input  logic             stop,
  output logic [PTR_W-1:0] insn_ptr,
  output logic             core_run,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LOAD_BEATS - 1);
  localparam logic [PTR_W-1:0] PTR_MAX   = '1;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PTR_W-1:0] ptr_q;
  logic             err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            err_q   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (data_valid) begin
            if (cnt_q == LAST_BEAT) begin
              state_q <= S_RUN;
              cnt_q   <= '0;
              ptr_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_RUN: begin
          // stop outranks stall, stall drops a concurrent branch
          if (stop) begin
            state_q <= S_DONE;
          end else if (stall) begin
            ptr_q <= ptr_q;
          end else if (branch_en) begin
            ptr_q <= branch_target;
          end else if (ptr_q == PTR_MAX) begin
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          ptr_q   <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_ready        = (state_q == S_LOAD);
  assign init_insn_mem     = (state_q == S_LOAD) && data_valid;
  assign insn_load_counter = cnt_q;
  assign insn_ptr          = ptr_q;
  assign core_run          = (state_q == S_RUN);
  assign busy              = (state_q != S_IDLE);
  assign done              = (state_q == S_DONE);
  assign err               = err_q;

endmodule
